me_search_engine: RTL and testbench

Parametrised full-search block-matching motion estimator, the next generation of the fixed 16x16 / ±8 estimator core. It takes a `start` command and streams reference-block pixels and search-window pixels from two external synchronous-read memories. It accumulates the sum of absolute differences (SAD) for every candidate displacement, then reports the best motion vector and its distance with a one-cycle `completed` pulse. New in this generation:

- block size, search range and pixel width are parameters;
- optional early termination, by per-candidate pruning and a whole-search threshold exit;
- a mid-search `abort` input.

The block sits between the memory model/driver and the scoreboard, in the same place as its predecessor.

---
 rtl/me_pkg.sv | 24 ++
 rtl/me_sad_acc.sv | 38 +++
 rtl/me_search_engine.sv | 181 ++++++++++++++++++
 tb/tb_me_search_engine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types, default parameters and width helpers for the motion-estimation search engine.
package me_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } me_state_t;

  localparam int unsigned BLOCK_DEF = 16;
  localparam int unsigned RANGE_DEF = 8;
  localparam int unsigned PIX_W_DEF = 8;

  // Wide enough for BLOCK*BLOCK full-scale differences, so the SAD never wraps.
  function automatic int unsigned dist_width(input int unsigned pix_w, input int unsigned block);
    return pix_w + 2 * $clog2(block);
  endfunction

  function automatic int unsigned mv_width(input int unsigned range);
    return $clog2(2 * range);
  endfunction

endpackage

// File: rtl/me_sad_acc.sv
// Absolute-difference and accumulate datapath; sad is the running total including this pixel.
module me_sad_acc
  import me_pkg::*;
#(
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned DIST_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic              last,
  input  logic [PIX_W-1:0]  r_data,
  input  logic [PIX_W-1:0]  s_data,
  output logic [DIST_W-1:0] acc,
  output logic [DIST_W-1:0] sad
);

  logic [PIX_W-1:0]  diff;
  logic [DIST_W-1:0] acc_q;

  always_comb begin
    diff = (r_data > s_data) ? (r_data - s_data) : (s_data - r_data);
  end

  assign acc = acc_q;
  assign sad = acc_q + DIST_W'(diff);

  // clear drops the pixel presented this cycle along with the partial sum.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q <= '0;
    end else if (valid) begin
      acc_q <= last ? '0 : sad;
    end
  end

endmodule

// File: rtl/me_search_engine.sv
// Full-search block-matching motion estimator with optional pruning and threshold exit.
module me_search_engine
  import me_pkg::*;
#(
  parameter int unsigned BLOCK = BLOCK_DEF,
  parameter int unsigned RANGE = RANGE_DEF,
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic                                    early_en,
  input  logic [dist_width(PIX_W, BLOCK)-1:0]     thresh,
  output logic [$clog2(BLOCK*BLOCK)-1:0]          addr_r,
  input  logic [PIX_W-1:0]                        r_data,
  output logic [$clog2((BLOCK+2*RANGE-1)**2)-1:0] addr_s,
  input  logic [PIX_W-1:0]                        s_data,
  output logic                                    rd_en,
  output logic                                    busy,
  output logic                                    completed,
  output logic [dist_width(PIX_W, BLOCK)-1:0]     best_dist,
  output logic [mv_width(RANGE)-1:0]              motion_x,
  output logic [mv_width(RANGE)-1:0]              motion_y
);

  localparam int unsigned W      = BLOCK + 2 * RANGE - 1;
  localparam int unsigned XW     = $clog2(BLOCK);
  localparam int unsigned SPAN   = 2 * RANGE;
  localparam int unsigned DIST_W = dist_width(PIX_W, BLOCK);
  localparam int unsigned MV_W   = mv_width(RANGE);
  localparam int unsigned AS_W   = $clog2(W * W);

  me_state_t state_q, state_d;
  logic [XW-1:0]     x_q, x_d, y_q, y_d;
  logic [MV_W-1:0]   u_q, u_d, v_q, v_d;     // dx+RANGE, dy+RANGE
  logic              valid_q, last_q;        // tags of the pixel whose data is on the bus
  logic [MV_W-1:0]   cu_q, cv_q;
  logic              early_q;
  logic [DIST_W-1:0] thresh_q;
  logic [DIST_W-1:0] best_q, best_d, acc, cand_sad;
  logic [MV_W-1:0]   bu_q, bu_d, bv_q, bv_d;
  logic              last_pix, last_cand, final_addr;
  logic              cand_better, exit_hit, prune_hit;

  assign last_pix   = (x_q == XW'(BLOCK - 1)) && (y_q == XW'(BLOCK - 1));
  assign last_cand  = (u_q == MV_W'(SPAN - 1)) && (v_q == MV_W'(SPAN - 1));
  assign final_addr = last_pix && last_cand;

  assign cand_better = valid_q && last_q && (cand_sad < best_q);
  assign exit_hit    = early_q && cand_better && (cand_sad <= thresh_q);
  // Only while data and address belong to the same candidate, i.e. in-flight pixel is not last.
  assign prune_hit   = early_q && (state_q == StRun) && valid_q && !last_q && (acc >= best_q);

  me_sad_acc #(
    .PIX_W  (PIX_W),
    .DIST_W (DIST_W)
  ) u_sad_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (prune_hit || (state_q == StIdle) || (state_q == StDone)),
    .valid  (valid_q),
    .last   (last_q),
    .r_data (r_data),
    .s_data (s_data),
    .acc    (acc),
    .sad    (cand_sad)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (exit_hit) begin
          state_d = StDone;
        end else if (final_addr || (prune_hit && last_cand)) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = abort ? StIdle : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    u_d = u_q;
    v_d = v_q;
    if (state_q != StRun || state_d != StRun) begin
      x_d = '0;
      y_d = '0;
      u_d = '0;
      v_d = '0;
    end else if (prune_hit || last_pix) begin
      x_d = '0;
      y_d = '0;
      if (u_q == MV_W'(SPAN - 1)) begin
        u_d = '0;
        v_d = v_q + 1'b1;
      end else begin
        u_d = u_q + 1'b1;
      end
    end else if (x_q == XW'(BLOCK - 1)) begin
      x_d = '0;
      y_d = y_q + 1'b1;
    end else begin
      x_d = x_q + 1'b1;
    end
  end

  always_comb begin
    best_d = best_q;
    bu_d   = bu_q;
    bv_d   = bv_q;
    if (cand_better) begin
      best_d = cand_sad;
      bu_d   = cu_q;
      bv_d   = cv_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      u_q       <= '0;
      v_q       <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      cu_q      <= '0;
      cv_q      <= '0;
      early_q   <= 1'b0;
      thresh_q  <= '0;
      best_q    <= '1;
      bu_q      <= '0;
      bv_q      <= '0;
      best_dist <= '0;
      motion_x  <= '0;
      motion_y  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      u_q     <= u_d;
      v_q     <= v_d;
      valid_q <= (state_q == StRun) && !abort && !prune_hit && !exit_hit;
      last_q  <= last_pix;
      cu_q    <= u_q;
      cv_q    <= v_q;
      if (state_q == StIdle && start) begin
        early_q  <= early_en;
        thresh_q <= thresh;
      end
      if (state_q == StIdle) begin
        best_q <= '1;
      end else begin
        best_q <= best_d;
      end
      bu_q <= bu_d;
      bv_q <= bv_d;
      if (state_d == StDone && state_q != StDone) begin
        best_dist <= best_d;
        motion_x  <= bu_d - MV_W'(RANGE);
        motion_y  <= bv_d - MV_W'(RANGE);
      end
    end
  end

  assign addr_r    = {y_q, x_q};
  assign addr_s    = AS_W'((32'(y_q) + 32'(v_q)) * W + 32'(x_q) + 32'(u_q));
  assign rd_en     = (state_q == StRun);
  assign busy      = (state_q != StIdle);
  assign completed = (state_q == StDone);

endmodule

// File: tb/tb_me_search_engine.sv
// Directed bench for me_search_engine at BLOCK=4, RANGE=2 with synchronous-read memory models.
module tb_me_search_engine;

  localparam int unsigned BLOCK = 4;
  localparam int unsigned RANGE = 2;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned W     = 7;

  logic        clk = 1'b0;
  logic        reset, start, abort, early_en;
  logic [11:0] thresh;
  logic [3:0]  addr_r;
  logic [5:0]  addr_s;
  logic [7:0]  r_data, s_data;
  logic        rd_en, busy, completed;
  logic [11:0] best_dist;
  logic [1:0]  motion_x, motion_y;

  logic [7:0] ref_mem  [16];
  logic [7:0] srch_mem [49];

  int n_cmp = 0;
  int n_err = 0;

  me_search_engine #(
    .BLOCK (BLOCK),
    .RANGE (RANGE),
    .PIX_W (PIX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .early_en  (early_en),
    .thresh    (thresh),
    .addr_r    (addr_r),
    .r_data    (r_data),
    .addr_s    (addr_s),
    .s_data    (s_data),
    .rd_en     (rd_en),
    .busy      (busy),
    .completed (completed),
    .best_dist (best_dist),
    .motion_x  (motion_x),
    .motion_y  (motion_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r_data <= ref_mem[addr_r];
    s_data <= srch_mem[addr_s];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_uniform(input logic [7:0] rv, input logic [7:0] sv);
    for (int i = 0; i < 16; i++) ref_mem[i] = rv;
    for (int i = 0; i < 49; i++) srch_mem[i] = sv;
  endtask

  // Distinct reference pixels copied into a background of 200 at displacement (dx,dy).
  task automatic fill_match(input int dx, input int dy);
    for (int i = 0; i < 49; i++) srch_mem[i] = 8'd200;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        ref_mem[y*4+x] = 8'(1 + 16*y + x);
        srch_mem[(y+dy+2)*W + (x+dx+2)] = 8'(1 + 16*y + x);
      end
    end
  endtask

  task automatic run_search(input logic en, input logic [11:0] th, input bit chk_addr,
                            output int lat);
    @(posedge clk); #1;
    early_en = en;
    thresh   = th;
    start    = 1'b1;
    lat = -1;
    for (int k = 1; k <= 400 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (chk_addr) begin
        if (k == 1) begin
          check_val("first_rd_en", 32'(rd_en), 1);
          check_val("first_addr_r", 32'(addr_r), 0);
          check_val("first_addr_s", 32'(addr_s), 0);
        end
        if (k == 2) begin
          check_val("pix1_addr_r", 32'(addr_r), 1);
          check_val("pix1_addr_s", 32'(addr_s), 1);
        end
        if (k == 17) begin
          check_val("cand1_addr_r", 32'(addr_r), 0);
          check_val("cand1_addr_s", 32'(addr_s), 1);
        end
        if (k == 256) begin
          check_val("last_addr_r", 32'(addr_r), 15);
          check_val("last_addr_s", 32'(addr_s), 48);
        end
        if (k == 257) begin
          check_val("drain_rd_en", 32'(rd_en), 0);
          check_val("drain_busy", 32'(busy), 1);
        end
      end
      if (completed) lat = k;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
      check_val("pulse_end", 32'(completed), 0);
      check_val("idle_busy", 32'(busy), 0);
    end
  endtask

  int lat;
  int ncomp;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; early_en = 1'b0; thresh = '0;
    fill_uniform(8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_completed", 32'(completed), 0);
    check_val("rst_rd_en", 32'(rd_en), 0);
    check_val("rst_addr_r", 32'(addr_r), 0);
    check_val("rst_addr_s", 32'(addr_s), 0);
    check_val("rst_best_dist", 32'(best_dist), 0);
    check_val("rst_motion_x", 32'(motion_x), 0);
    check_val("rst_motion_y", 32'(motion_y), 0);
    reset = 1'b0;

    fill_match(1, -2);
    run_search(1'b0, 12'd0, 1'b1, lat);
    check_val("match_latency", 32'(lat), 258);
    check_val("match_mx", 32'(motion_x), 1);
    check_val("match_my", 32'(motion_y), 2);
    check_val("match_dist", 32'(best_dist), 0);

    fill_uniform(8'h0A, 8'h0A);
    run_search(1'b0, 12'd0, 1'b0, lat);
    check_val("tie_latency", 32'(lat), 258);
    check_val("tie_mx", 32'(motion_x), 2);
    check_val("tie_my", 32'(motion_y), 2);
    check_val("tie_dist", 32'(best_dist), 0);

    fill_match(-2, -1);
    run_search(1'b1, 12'd0, 1'b0, lat);
    check_val("exit_latency_window", 32'(lat >= 34 && lat <= 82), 1);
    check_val("exit_mx", 32'(motion_x), 2);
    check_val("exit_my", 32'(motion_y), 3);
    check_val("exit_dist", 32'(best_dist), 0);

    fill_uniform(8'hFF, 8'h00);
    run_search(1'b0, 12'd0, 1'b0, lat);
    check_val("max_latency", 32'(lat), 258);
    check_val("max_dist", 32'(best_dist), 4080);
    check_val("max_mx", 32'(motion_x), 2);
    check_val("max_my", 32'(motion_y), 2);

    // Aborted run, with a stray start during RUN, then a fresh run.
    fill_match(1, -2);
    @(posedge clk); #1;
    early_en = 1'b0;
    start    = 1'b1;
    ncomp    = 0;
    for (int k = 1; k <= 109; k++) begin
      @(posedge clk); #1;
      start = (k == 50);
      abort = (k == 100);
      if (completed) ncomp++;
      if (k == 101) begin
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_rd_en", 32'(rd_en), 0);
      end
    end
    check_val("abort_no_completed", 32'(ncomp), 0);
    check_val("abort_hold_dist", 32'(best_dist), 4080);
    check_val("abort_hold_mx", 32'(motion_x), 2);
    check_val("abort_hold_my", 32'(motion_y), 2);
    run_search(1'b0, 12'd0, 1'b0, lat);
    check_val("rerun_latency", 32'(lat), 258);
    check_val("rerun_mx", 32'(motion_x), 1);
    check_val("rerun_my", 32'(motion_y), 2);
    check_val("rerun_dist", 32'(best_dist), 0);

    // Reset in the middle of a search, with non-zero outputs from an earlier run.
    fill_uniform(8'hFF, 8'h00);
    run_search(1'b0, 12'd0, 1'b0, lat);
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_busy", 32'(busy), 0);
    check_val("midrst_rd_en", 32'(rd_en), 0);
    check_val("midrst_addr_r", 32'(addr_r), 0);
    check_val("midrst_addr_s", 32'(addr_s), 0);
    check_val("midrst_dist", 32'(best_dist), 0);
    check_val("midrst_mx", 32'(motion_x), 0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
